// File: rtl/z80_io_uart_pkg.sv
// Shared definitions for the Z80 I/O-mapped UART: register offsets, status bit
// positions, transmitter/receiver state types and the baud divisor helper.
package z80_io_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_TXFULL  = 0;
    localparam int ST_TXEMPTY = 1;
    localparam int ST_RXAV    = 2;
    localparam int ST_RXOVR   = 3;
    localparam int ST_FERR    = 4;
    localparam int ST_TXOVF   = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Rounded clocks-per-bit so the bit period error stays within half a clock.
    function automatic int calcDiv(input int clkHz, input int baud);
        return (clkHz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/z80_io_uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO used for both UART directions.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

    // A simultaneous pop frees the slot being written, so a push into a full FIFO still lands.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/z80_io_uart.sv
// z80_io_uart: FIFO-buffered 8N1 UART decoded from Z80 I/O cycles at BASE_PORT+0..+2.
// Define Z80_UART_IRQ_EN to build the control register and the registered nint output.
module z80_io_uart #(
    parameter logic [7:0] BASE_PORT = 8'h00,
    parameter int         CLK_HZ    = 10000000,
    parameter int         BAUD      = 115200,
    parameter int         TX_DEPTH  = 16,
    parameter int         RX_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] A,
    input  logic       nIORQ,
    input  logic       nRD,
    input  logic       nWR,
    input  logic       nM1,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       nint,
    input  logic       uart_rx,
    output logic       uart_tx
);

    import z80_io_uart_pkg::*;

    localparam int            DIV      = calcDiv(CLK_HZ, BAUD);
    localparam int            CW       = $clog2(DIV) + 1;
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

    logic [7:0] offset;
    logic [1:0] regSel;
    logic       sel, wrAct, rdAct;
    logic       wrAct_q, rdAct_q;
    logic [1:0] rdReg_q;
    logic       wrPulse, rdTrail, statusClr;
    logic [7:0] rdData, status, ctrlRead;

    logic       txPush, txPop, txFull, txFifoEmpty, txOvfSet, txEmptyFlag;
    logic [7:0] txHead;
    logic       rxPush, rxPop, rxFull, rxEmpty, rxOvrSet, fErrSet, rxAvail;
    logic [7:0] rxHead;
    logic       txOvf_q, fErr_q, rxOvr_q;

    tx_state_t     txState_q, txState_d;
    logic [CW-1:0] txCnt_q, txCnt_d;
    logic [2:0]    txBit_q, txBit_d;
    logic [7:0]    txShift_q, txShift_d;
    logic          txLine_q, txLine_d;

    rx_state_t     rxState_q, rxState_d;
    logic [CW-1:0] rxCnt_q, rxCnt_d;
    logic [2:0]    rxBit_q, rxBit_d;
    logic [7:0]    rxShift_q, rxShift_d;
    logic [1:0]    rxSync_q;
    logic          rxPrev_q, rxIn;

    assign offset  = A - BASE_PORT;
    assign regSel  = offset[1:0];
    assign sel     = !nIORQ && nM1 && (offset < 8'd3);
    assign wrAct   = sel && !nWR;
    assign rdAct   = sel && !nRD;
    assign wrPulse = wrAct && !wrAct_q;
    assign rdTrail = !rdAct && rdAct_q;

    // The register being read is remembered so its side effect lands after A has moved on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrAct_q <= 1'b0;
            rdAct_q <= 1'b0;
            rdReg_q <= REG_DATA;
        end else begin
            wrAct_q <= wrAct;
            rdAct_q <= rdAct;
            if (rdAct) rdReg_q <= regSel;
        end
    end

    assign statusClr   = rdTrail && (rdReg_q == REG_STATUS);
    assign txPush      = wrPulse && (regSel == REG_DATA);
    assign rxPop       = rdTrail && (rdReg_q == REG_DATA);
    assign txOvfSet    = txPush && txFull && !txPop;
    assign rxOvrSet    = rxPush && rxFull && !rxPop;
    assign txEmptyFlag = txFifoEmpty && (txState_q == TX_IDLE);
    assign rxAvail     = !rxEmpty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txOvf_q <= 1'b0;
            fErr_q  <= 1'b0;
            rxOvr_q <= 1'b0;
        end else begin
            txOvf_q <= txOvfSet || (txOvf_q && !statusClr);
            fErr_q  <= fErrSet  || (fErr_q  && !statusClr);
            rxOvr_q <= rxOvrSet || (rxOvr_q && !statusClr);
        end
    end

    always_comb begin
        status             = '0;
        status[ST_TXFULL]  = txFull;
        status[ST_TXEMPTY] = txEmptyFlag;
        status[ST_RXAV]    = rxAvail;
        status[ST_RXOVR]   = rxOvr_q;
        status[ST_FERR]    = fErr_q;
        status[ST_TXOVF]   = txOvf_q;
    end

    always_comb begin
        rdData = 8'h00;
        case (regSel)
            REG_DATA:   rdData = rxEmpty ? 8'h00 : rxHead;
            REG_STATUS: rdData = status;
            REG_CTRL:   rdData = ctrlRead;
            default:    rdData = 8'h00;
        endcase
    end

    assign d_oe  = rdAct;
    assign d_out = rdAct ? rdData : 8'h00;

`ifdef Z80_UART_IRQ_EN
    logic [1:0] ctrl_q;
    logic       nint_q;

    // Bit 0 enables the TX-empty interrupt, bit 1 the RX-available interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= 2'b00;
            nint_q <= 1'b1;
        end else begin
            if (wrPulse && (regSel == REG_CTRL)) ctrl_q <= d_in[1:0];
            nint_q <= !((ctrl_q[0] && txEmptyFlag) || (ctrl_q[1] && rxAvail));
        end
    end

    assign ctrlRead = {6'b0, ctrl_q};
    assign nint     = nint_q;
`else
    assign ctrlRead = 8'h00;
    assign nint     = 1'b1;
`endif

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) txFifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (txPush),
        .wdata_i (d_in),
        .pop_i   (txPop),
        .rdata_o (txHead),
        .full_o  (txFull),
        .empty_o (txFifoEmpty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rxFifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rxPush),
        .wdata_i (rxShift_q),
        .pop_i   (rxPop),
        .rdata_o (rxHead),
        .full_o  (rxFull),
        .empty_o (rxEmpty)
    );

    always_comb begin
        txState_d = txState_q;
        txCnt_d   = txCnt_q + CW'(1);
        txBit_d   = txBit_q;
        txShift_d = txShift_q;
        txPop     = 1'b0;
        case (txState_q)
            TX_IDLE: begin
                txCnt_d = '0;
                if (!txFifoEmpty) begin
                    txPop     = 1'b1;
                    txShift_d = txHead;
                    txState_d = TX_START;
                end
            end
            TX_START: begin
                if (txCnt_q == BIT_END) begin
                    txCnt_d   = '0;
                    txBit_d   = 3'd0;
                    txState_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (txCnt_q == BIT_END) begin
                    txCnt_d   = '0;
                    txShift_d = {1'b0, txShift_q[7:1]};
                    txBit_d   = txBit_q + 3'd1;
                    if (txBit_q == 3'd7) txState_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (txCnt_q == BIT_END) begin
                    txCnt_d = '0;
                    if (!txFifoEmpty) begin
                        txPop     = 1'b1;
                        txShift_d = txHead;
                        txState_d = TX_START;
                    end else begin
                        txState_d = TX_IDLE;
                    end
                end
            end
            default: txState_d = TX_IDLE;
        endcase
        // The line level is registered from the next state so uart_tx never glitches.
        case (txState_d)
            TX_START: txLine_d = 1'b0;
            TX_DATA:  txLine_d = txShift_d[0];
            default:  txLine_d = 1'b1;
        endcase
    end

    assign rxIn = rxSync_q[1];

    always_comb begin
        rxState_d = rxState_q;
        rxCnt_d   = rxCnt_q + CW'(1);
        rxBit_d   = rxBit_q;
        rxShift_d = rxShift_q;
        rxPush    = 1'b0;
        fErrSet   = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                rxCnt_d = '0;
                if (rxPrev_q && !rxIn) rxState_d = RX_START;
            end
            RX_START: begin
                if (rxCnt_q == HALF_END) begin
                    rxCnt_d   = '0;
                    rxBit_d   = 3'd0;
                    rxState_d = rxIn ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rxCnt_q == BIT_END) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxIn, rxShift_q[7:1]};
                    rxBit_d   = rxBit_q + 3'd1;
                    if (rxBit_q == 3'd7) rxState_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rxCnt_q == BIT_END) begin
                    rxCnt_d   = '0;
                    rxPush    = rxIn;
                    fErrSet   = !rxIn;
                    rxState_d = RX_IDLE;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= 3'd0;
            txShift_q <= 8'h00;
            txLine_q  <= 1'b1;
            rxState_q <= RX_IDLE;
            rxCnt_q   <= '0;
            rxBit_q   <= 3'd0;
            rxShift_q <= 8'h00;
            rxSync_q  <= 2'b11;
            rxPrev_q  <= 1'b1;
        end else begin
            txState_q <= txState_d;
            txCnt_q   <= txCnt_d;
            txBit_q   <= txBit_d;
            txShift_q <= txShift_d;
            txLine_q  <= txLine_d;
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxBit_q   <= rxBit_d;
            rxShift_q <= rxShift_d;
            rxSync_q  <= {rxSync_q[0], uart_rx};
            rxPrev_q  <= rxIn;
        end
    end

    assign uart_tx = txLine_q;

endmodule

// File: tb/tb_z80_io_uart.sv
// Directed testbench for z80_io_uart: Z80 I/O bus cycles plus bit-level serial stimulus.
// IRQ checks follow the Z80_UART_IRQ_EN build option.
module tb_z80_io_uart;

    localparam logic [7:0] BASE = 8'h00;
    localparam int         BITCLK = 87;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] A;
    logic       nIORQ, nRD, nWR, nM1;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic       nint;
    logic       uart_rx;
    logic       uart_tx;

    int vectorCount = 0;
    int missCount   = 0;
    int cycleCount  = 0;
    int txFallCycle = -1;
    logic txPrev = 1'b1;

    z80_io_uart dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .nIORQ   (nIORQ),
        .nRD     (nRD),
        .nWR     (nWR),
        .nM1     (nM1),
        .d_in    (d_in),
        .d_out   (d_out),
        .d_oe    (d_oe),
        .nint    (nint),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cycleCount = cycleCount + 1;

    // Records the cycle of every high-to-low transition on the serial output.
    always @(negedge clk) begin
        if (txPrev === 1'b1 && uart_tx === 1'b0) txFallCycle = cycleCount;
        txPrev = uart_tx;
    end

    initial begin
        #6000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One OUT cycle with a wait state; ends on a falling clock edge.
    task automatic applyStimulus(input logic [7:0] port, input logic [7:0] data);
        A = BASE + port; d_in = data; nIORQ = 1'b0; nWR = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nIORQ = 1'b1; nWR = 1'b1;
        @(negedge clk);
    endtask

    task automatic ioRead(input logic [7:0] port, output logic [7:0] data);
        A = BASE + port; nIORQ = 1'b0; nRD = 1'b0;
        @(negedge clk);
        checkOutput("rdOe", d_oe, 1);
        data = d_out;
        nIORQ = 1'b1; nRD = 1'b1;
        @(negedge clk);
    endtask

    task automatic sendRxFrame(input logic [7:0] data, input logic stopBit);
        uart_rx = 1'b0;
        repeat (BITCLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (BITCLK) @(negedge clk);
        end
        uart_rx = stopBit;
        repeat (BITCLK) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic waitCycle(input int target);
        while (cycleCount < target) @(negedge clk);
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  rd;
        logic [19:0] frame;
        int          f;

        reset = 1'b0; A = 8'h00; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
        d_in = 8'h00; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstTx", uart_tx, 1);
        checkOutput("rstNint", nint, 1);
        checkOutput("rstDoe", d_oe, 0);
        checkOutput("rstDout", d_out, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        ioRead(8'd1, rd);
        checkOutput("rstStatus", rd, 8'h02);

        $display("[TB] reset during a frame");
        applyStimulus(8'd0, 8'h00);
        repeat (100) @(negedge clk);
        checkOutput("midFrameTx", uart_tx, 0);
        #10 reset = 1'b0;
        #1 checkOutput("rstAbortTx", uart_tx, 1);
        checkOutput("rstAbortNint", nint, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ioRead(8'd1, rd);
        checkOutput("postRstStatus", rd, 8'h02);

        $display("[TB] back-to-back transmit");
        txFallCycle = -1;
        applyStimulus(8'd0, 8'h55);
        applyStimulus(8'd0, 8'hA3);
        ioRead(8'd1, rd);
        checkOutput("txBusyStatus", rd, 8'h00);
        checkOutput("txStartSeen", txFallCycle >= 0, 1);
        if (txFallCycle >= 0) begin
            f = txFallCycle;
            frame = {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0};
            for (int i = 0; i < 20; i++) begin
                waitCycle(f + BITCLK / 2 + BITCLK * i);
                checkOutput($sformatf("txBit%0d", i), uart_tx, frame[i]);
            end
            waitCycle(f + BITCLK * 20 + 4);
            ioRead(8'd1, rd);
            checkOutput("txDoneStatus", rd, 8'h02);
        end

        $display("[TB] transmit FIFO fill and overflow");
        pulseReset();
        for (int i = 0; i < 17; i++) applyStimulus(8'd0, 8'(i));
        ioRead(8'd1, rd);
        checkOutput("tx17Status", rd, 8'h01);
        pulseReset();
        for (int i = 0; i < 18; i++) applyStimulus(8'd0, 8'(i));
        ioRead(8'd1, rd);
        checkOutput("tx18Status", rd, 8'h21);
        ioRead(8'd1, rd);
        checkOutput("txOvfCleared", rd, 8'h01);
        pulseReset();

        $display("[TB] receive");
        ioRead(8'd0, rd);
        checkOutput("rxEmptyRead", rd, 8'h00);
        sendRxFrame(8'hC4, 1'b1);
        ioRead(8'd1, rd);
        checkOutput("rxAvStatus", rd, 8'h06);
        ioRead(8'd0, rd);
        checkOutput("rxData", rd, 8'hC4);
        ioRead(8'd1, rd);
        checkOutput("rxDrainedStatus", rd, 8'h02);
        checkOutput("idleDout", d_out, 8'h00);

        $display("[TB] framing error and glitch");
        sendRxFrame(8'h5A, 1'b0);
        repeat (BITCLK) @(negedge clk);
        ioRead(8'd1, rd);
        checkOutput("ferrStatus", rd, 8'h12);
        ioRead(8'd1, rd);
        checkOutput("ferrCleared", rd, 8'h02);
        uart_rx = 1'b0;
        repeat (20) @(negedge clk);
        uart_rx = 1'b1;
        repeat (100) @(negedge clk);
        ioRead(8'd1, rd);
        checkOutput("glitchStatus", rd, 8'h02);

        $display("[TB] receive overrun");
        for (int i = 0; i < 17; i++) sendRxFrame(8'h30 + 8'(i), 1'b1);
        ioRead(8'd1, rd);
        checkOutput("rxOvrStatus", rd, 8'h0E);
        for (int i = 0; i < 16; i++) begin
            ioRead(8'd0, rd);
            checkOutput($sformatf("rxOrder%0d", i), rd, 8'h30 + 8'(i));
        end
        ioRead(8'd1, rd);
        checkOutput("rxOvrCleared", rd, 8'h02);

        $display("[TB] interrupt path");
`ifdef Z80_UART_IRQ_EN
        applyStimulus(8'd2, 8'h02);
        ioRead(8'd2, rd);
        checkOutput("ctrlRead", rd, 8'h02);
        checkOutput("nintIdle", nint, 1);
        sendRxFrame(8'h3C, 1'b1);
        checkOutput("nintRxAv", nint, 0);
        ioRead(8'd0, rd);
        checkOutput("irqData", rd, 8'h3C);
        checkOutput("nintHold", nint, 0);
        @(negedge clk);
        checkOutput("nintRelease", nint, 1);
`else
        applyStimulus(8'd2, 8'h02);
        ioRead(8'd2, rd);
        checkOutput("ctrlAbsent", rd, 8'h00);
        sendRxFrame(8'h3C, 1'b1);
        checkOutput("nintTied", nint, 1);
        ioRead(8'd0, rd);
        checkOutput("irqData", rd, 8'h3C);
        checkOutput("nintStill", nint, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
